alu_ctrl_stage: RTL and testbench

//  Registered decode->execute control stage: decodes ALU operation, immediate and operand-B select from a 32-bit RV instruction.

---
 rtl/alu_ctrl_stage_pkg.sv | 49 ++++
 rtl/alu_ctrl_stage_if.sv | 32 +++
 rtl/alu_ctrl_stage_imm_gen.sv | 66 ++++++
 rtl/alu_ctrl_stage.sv | 150 +++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_stage_pkg.sv
// Shared constants for the decode->execute ALU control stage.
// ALU_MEXT_EN widens ALU op codes to 5 bits and adds the M-extension ops.
package alu_ctrl_stage_pkg;

`ifdef ALU_MEXT_EN
  localparam int OP_W = 5;
`else
  localparam int OP_W = 4;
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(4'b1101);

`ifdef ALU_MEXT_EN
  localparam logic [OP_W-1:0] ALU_MUL    = 5'b10000;
  localparam logic [OP_W-1:0] ALU_MULH   = 5'b10001;
  localparam logic [OP_W-1:0] ALU_MULHSU = 5'b10010;
  localparam logic [OP_W-1:0] ALU_MULHU  = 5'b10011;
  localparam logic [OP_W-1:0] ALU_DIV    = 5'b10100;
  localparam logic [OP_W-1:0] ALU_DIVU   = 5'b10101;
  localparam logic [OP_W-1:0] ALU_REM    = 5'b10110;
  localparam logic [OP_W-1:0] ALU_REMU   = 5'b10111;
`endif

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Upstream/downstream handshake bundle for the ALU control stage.
// Op width follows ALU_MEXT_EN through the package.
interface alu_ctrl_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  import alu_ctrl_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_alu_op;
  logic [XLEN-1:0]   out_imm;
  logic              out_use_imm;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_alu_op,
    input  out_imm, out_use_imm, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_alu_op,
    output out_imm, out_use_imm, out_tag
  );

endinterface

// File: rtl/alu_ctrl_stage_imm_gen.sv
// Immediate extraction and operand-B select from an RV instruction.
// All immediates sign-extend from inst[31] to XLEN.
module alu_ctrl_stage_imm_gen
  import alu_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            use_imm
);

  logic [6:0]  opc;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;

  assign opc   = inst[6:0];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // pick the immediate format and operand-B source per opcode
  always_comb begin
    imm32   = '0;
    use_imm = 1'b0;
    unique case (1'b1)
      opc == OPC_OP_IMM,
      opc == OPC_LOAD,
      opc == OPC_JALR: begin
        imm32   = imm_i;
        use_imm = 1'b1;
      end
      opc == OPC_STORE: begin
        imm32   = imm_s;
        use_imm = 1'b1;
      end
      opc == OPC_BRANCH: begin
        imm32   = imm_b;
      end
      opc == OPC_LUI,
      opc == OPC_AUIPC: begin
        imm32   = imm_u;
        use_imm = 1'b1;
      end
      opc == OPC_JAL: begin
        imm32   = imm_j;
        use_imm = 1'b1;
      end
      default: begin
        imm32   = '0;
        use_imm = 1'b0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered decode->execute ALU control stage with 2-entry skid buffer.
// Optional M-extension decode under `ALU_MEXT_EN.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  alu_ctrl_stage_if.slave  io
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [TAG_W-1:0] tag;
  } ent_t;

  function automatic logic [OP_W-1:0] alu_dec(
    input logic [31:0] i
  );
    logic [2:0]      f3;
    logic [6:0]      opc;
    logic [OP_W-1:0] op;
    f3  = i[14:12];
    opc = i[6:0];
    op  = ALU_ADD;
    unique case (1'b1)
      opc == OPC_OP: begin
`ifdef ALU_MEXT_EN
        if (i[31:25] == 7'b0000001)
          op = {2'b10, f3};
        else
          op = {1'b0, i[30], f3};
`else
        op = {i[30], f3};
`endif
      end
      opc == OPC_OP_IMM: begin
        op = OP_W'({i[30] & (f3 == 3'b101), f3});
      end
      opc == OPC_BRANCH: begin
        unique case (f3[2:1])
          2'b00:   op = ALU_SUB;
          2'b10:   op = ALU_SLT;
          2'b11:   op = ALU_SLTU;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  occ_e state_q;
  occ_e state_d;
  ent_t main_q;
  ent_t skid_q;
  ent_t dec;
  logic acc;
  logic iss;
  logic ld_main_dec;
  logic ld_main_skid;
  logic ld_skid_dec;

  alu_ctrl_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst    (io.in_inst),
    .imm     (dec.imm),
    .use_imm (dec.use_imm)
  );

  assign dec.op  = alu_dec(io.in_inst);
  assign dec.tag = io.in_tag;

  assign io.in_ready    = (state_q != OCC_FULL);
  assign io.out_valid   = (state_q != OCC_EMPTY);
  assign io.out_alu_op  = main_q.op;
  assign io.out_imm     = main_q.imm;
  assign io.out_use_imm = main_q.use_imm;
  assign io.out_tag     = main_q.tag;

  assign acc = io.in_valid & io.in_ready;
  assign iss = io.out_valid & io.out_ready;

  // occupancy state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state_q <= OCC_EMPTY;
    else
      state_q <= state_d;
  end

  // next occupancy and register load steering; flush drops everything
  always_comb begin
    state_d      = state_q;
    ld_main_dec  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_dec  = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (acc) begin
            state_d     = OCC_ONE;
            ld_main_dec = 1'b1;
          end
        end
        OCC_ONE: begin
          if (acc && !iss) begin
            state_d     = OCC_FULL;
            ld_skid_dec = 1'b1;
          end else if (acc && iss) begin
            ld_main_dec = 1'b1;
          end else if (iss) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (iss) begin
            state_d      = OCC_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // main entry drives the outputs; skid catches overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '{op: ALU_ADD, default: '0};
      skid_q <= '{op: ALU_ADD, default: '0};
    end else begin
      if (ld_main_dec)
        main_q <= dec;
      else if (ld_main_skid)
        main_q <= skid_q;
      if (ld_skid_dec)
        skid_q <= dec;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage (XLEN=64).
// Expected values are hand-decoded instruction fields.
module tb_alu_ctrl_stage;
  import alu_ctrl_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] issued[$];

  alu_ctrl_stage_if #(.XLEN(64), .TAG_W(32)) bus();

  alu_ctrl_stage #(
    .XLEN  (64),
    .TAG_W (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  always #5 clock = ~clock;

  // record every issued tag in order
  always @(posedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready)
      issued.push_back(bus.out_tag);
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dec_chk(input string tag,
                         input logic [31:0] inst,
                         input logic [63:0] op_e,
                         input logic [63:0] imm_e,
                         input logic use_e);
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_tag    = inst;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_op"}, 64'(bus.out_alu_op), op_e);
    check({tag, "_imm"}, bus.out_imm, imm_e);
    check({tag, "_use"}, 64'(bus.out_use_imm), 64'(use_e));
    check({tag, "_tag"}, 64'(bus.out_tag), 64'(inst));
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    check("rst_rdy", 64'(bus.in_ready), 64'd1);
    check("rst_op", 64'(bus.out_alu_op), 64'd0);
    check("rst_imm", bus.out_imm, 64'd0);
    check("rst_use", 64'(bus.out_use_imm), 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;
    step();

    dec_chk("add", 32'h003100B3, 64'h0, 64'h0, 1'b0);
    dec_chk("srai", 32'h4020D093, 64'hD, 64'h402, 1'b1);
    dec_chk("slli", 32'h00209093, 64'h1, 64'h002, 1'b1);
    dec_chk("sub", 32'h40000033, 64'h8, 64'h0, 1'b0);
    dec_chk("beq", 32'hFE000EE3, 64'h8,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    dec_chk("bltu", 32'hFE006EE3, 64'h3,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    dec_chk("blt", 32'h00004463, 64'h2, 64'h8, 1'b0);
    dec_chk("lw", 32'hFFF12083, 64'h0,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    dec_chk("sw", 32'h00312423, 64'h0, 64'h8, 1'b1);
    dec_chk("lui", 32'h800000B7, 64'h0,
            64'hFFFF_FFFF_8000_0000, 1'b1);
    dec_chk("jal", 32'h0040006F, 64'h0, 64'h4, 1'b1);
    dec_chk("bad", 32'hFFFFFFFF, 64'h0, 64'h0, 1'b0);
`ifdef ALU_MEXT_EN
    dec_chk("mul", 32'h02208033, 64'h10, 64'h0, 1'b0);
`else
    dec_chk("mul", 32'h02208033, 64'h0, 64'h0, 1'b0);
`endif

    // stall stream: A,B fill the stage, C waits, D follows
    issued.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h003100B3;
    bus.in_tag    = 32'hA;
    step();
    check("s_rdy1", 64'(bus.in_ready), 64'd1);
    check("s_tagA", 64'(bus.out_tag), 64'hA);
    bus.in_tag = 32'hB;
    step();
    check("s_rdy0", 64'(bus.in_ready), 64'd0);
    check("s_holdA", 64'(bus.out_tag), 64'hA);
    bus.in_tag = 32'hC;
    step();
    check("s_rdy0b", 64'(bus.in_ready), 64'd0);
    check("s_holdA2", 64'(bus.out_tag), 64'hA);
    check("s_vld", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    step();
    check("s_tagB", 64'(bus.out_tag), 64'hB);
    check("s_rdy2", 64'(bus.in_ready), 64'd1);
    step();
    check("s_tagC", 64'(bus.out_tag), 64'hC);
    bus.in_tag = 32'hD;
    step();
    check("s_tagD", 64'(bus.out_tag), 64'hD);
    bus.in_valid = 1'b0;
    step();
    check("s_empty", 64'(bus.out_valid), 64'd0);
    check("s_cnt", 64'(issued.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("s_ord%0d", i),
            64'(issued[i]), 64'(32'hA + i));

    // flush while FULL with a pending input
    issued.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 32'hE;
    step();
    bus.in_tag = 32'hF;
    step();
    check("f_full", 64'(bus.in_ready), 64'd0);
    bus.in_tag = 32'h11;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("f_vld", 64'(bus.out_valid), 64'd0);
    check("f_rdy", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("f_vld2", 64'(bus.out_valid), 64'd0);

    // flush in ONE overrides a same-cycle accept
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 32'h12;
    step();
    bus.in_tag = 32'h13;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("f1_vld", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    repeat (2) step();
    check("f_none", 64'(issued.size()), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_tag   = 32'h14;
    step();
    bus.in_valid = 1'b0;
    check("f_tagJ", 64'(bus.out_tag), 64'h14);
    step();
    check("f_cnt", 64'(issued.size()), 64'd1);
    check("f_only", 64'(issued[0]), 64'h14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
